// File: rtl/axi_lite_to_reg_pkg.sv
// ============================================================================
// Module : axi_lite_to_reg_pkg
// Brief  : FSM states, AXI response codes and counter sizing for the bridge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_lite_to_reg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        RD_REQ = 3'd2,
        WR_RSP = 3'd3,
        RD_RSP = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // A disabled timeout still needs a legal one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_intf.sv
// ============================================================================
// Module : reg_intf
// Brief  : Request/response typedefs for the 32-bit address, 32-bit data register bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package reg_intf;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_intf_req_a32_d32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_intf_resp_d32;

endpackage

`default_nettype wire

// File: rtl/axi_lite_to_reg.sv
// ============================================================================
// Module : axi_lite_to_reg
// Brief  : AXI-Lite slave to reg_intf initiator, one outstanding access, fair
//          read/write arbitration and a target response timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_to_reg
    import axi_lite_to_reg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [31:0]                   aw_addr_i,
    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    input  logic [31:0]                   w_data_i,
    input  logic [3:0]                    w_strb_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    output logic [1:0]                    b_resp_o,
    output logic                          b_valid_o,
    input  logic                          b_ready_i,
    input  logic [31:0]                   ar_addr_i,
    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    output logic [31:0]                   r_data_o,
    output logic [1:0]                    r_resp_o,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output reg_intf::reg_intf_req_a32_d32 reg_req_o,
    input  reg_intf::reg_intf_resp_d32    reg_rsp_i
);

    localparam int unsigned TIMEOUT_W = cnt_width(TIMEOUT);
    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_LAST_I[TIMEOUT_W-1:0];

    state_e                       state_q;
    reg_intf::reg_intf_req_a32_d32 req_q;
    logic [1:0]                   b_resp_q;
    logic                         b_valid_q;
    logic [31:0]                  r_data_q;
    logic [1:0]                   r_resp_q;
    logic                         r_valid_q;
    logic                         last_was_write_q;
    logic                         served_q;
    logic [TIMEOUT_W-1:0]         cnt_q;

    logic wr_pend;
    logic rd_pend;
    logic pick_wr;
    logic pick_rd;
    logic timed_out;
    logic [1:0] rsp_code;

    assign wr_pend = aw_valid_i & w_valid_i;
    assign rd_pend = ar_valid_i;

    // Ties go to the channel not served last; out of reset a read wins the first tie.
    assign pick_wr = (state_q == IDLE) & wr_pend &
                     (~rd_pend | (served_q & ~last_was_write_q));
    assign pick_rd = (state_q == IDLE) & rd_pend & ~pick_wr;

    assign aw_ready_o = rst_ni & pick_wr;
    assign w_ready_o  = rst_ni & pick_wr;
    assign ar_ready_o = rst_ni & pick_rd;

    // The final waiting cycle is the one where the counter would reach TIMEOUT.
    assign timed_out = (TIMEOUT != 0) & ~reg_rsp_i.ready & (cnt_q == TO_LAST);
    assign rsp_code  = (timed_out | reg_rsp_i.error) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            req_q            <= '0;
            b_resp_q         <= RESP_OKAY;
            b_valid_q        <= 1'b0;
            r_data_q         <= '0;
            r_resp_q         <= RESP_OKAY;
            r_valid_q        <= 1'b0;
            last_was_write_q <= 1'b0;
            served_q         <= 1'b0;
            cnt_q            <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_wr) begin
                        req_q.addr  <= aw_addr_i;
                        req_q.write <= 1'b1;
                        req_q.wdata <= w_data_i;
                        req_q.wstrb <= w_strb_i;
                        req_q.valid <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WR_REQ;
                    end else if (pick_rd) begin
                        req_q.addr  <= ar_addr_i;
                        req_q.write <= 1'b0;
                        req_q.wdata <= '0;
                        req_q.wstrb <= '0;
                        req_q.valid <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (reg_rsp_i.ready || timed_out) begin
                        req_q.valid <= 1'b0;
                        b_resp_q    <= rsp_code;
                        b_valid_q   <= 1'b1;
                        state_q     <= WR_RSP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (reg_rsp_i.ready || timed_out) begin
                        req_q.valid <= 1'b0;
                        r_resp_q    <= rsp_code;
                        r_data_q    <= timed_out ? 32'h0 : reg_rsp_i.rdata;
                        r_valid_q   <= 1'b1;
                        state_q     <= RD_RSP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WR_RSP: begin
                    if (b_ready_i) begin
                        b_valid_q        <= 1'b0;
                        last_was_write_q <= 1'b1;
                        served_q         <= 1'b1;
                        state_q          <= IDLE;
                    end
                end
                RD_RSP: begin
                    if (r_ready_i) begin
                        r_valid_q        <= 1'b0;
                        last_was_write_q <= 1'b0;
                        served_q         <= 1'b1;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reg_req_o = req_q;
    assign b_resp_o  = b_resp_q;
    assign b_valid_o = b_valid_q;
    assign r_data_o  = r_data_q;
    assign r_resp_o  = r_resp_q;
    assign r_valid_o = r_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_to_reg.sv
// ============================================================================
// Module : tb_axi_lite_to_reg
// Brief  : Self-checking bench for axi_lite_to_reg with a scripted register target.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_to_reg;
    import reg_intf::*;

    localparam int unsigned TO     = 4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic        aw_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b0;
    reg_intf_req_a32_d32 reg_req;
    reg_intf_resp_d32    reg_rsp;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Target: answers after tgt_delay low-ready cycles of a valid request.
    int          tgt_delay = 0;
    logic        tgt_err   = 1'b0;
    logic [31:0] tgt_rdata = '0;
    int          wait_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reg_req.valid) wait_cnt <= 0;
        else                wait_cnt <= wait_cnt + 1;
    end

    always_comb begin
        reg_rsp       = '0;
        reg_rsp.ready = reg_req.valid && (wait_cnt == tgt_delay);
        reg_rsp.error = tgt_err;
        reg_rsp.rdata = tgt_rdata;
    end

    axi_lite_to_reg #(.TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .aw_addr_i  (aw_addr),
        .aw_valid_i (aw_valid),
        .aw_ready_o (aw_ready),
        .w_data_i   (w_data),
        .w_strb_i   (w_strb),
        .w_valid_i  (w_valid),
        .w_ready_o  (w_ready),
        .b_resp_o   (b_resp),
        .b_valid_o  (b_valid),
        .b_ready_i  (b_ready),
        .ar_addr_i  (ar_addr),
        .ar_valid_i (ar_valid),
        .ar_ready_o (ar_ready),
        .r_data_o   (r_data),
        .r_resp_o   (r_resp),
        .r_valid_o  (r_valid),
        .r_ready_i  (r_ready),
        .reg_req_o  (reg_req),
        .reg_rsp_i  (reg_rsp)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; expectations follow from the access kind and target behaviour.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int delay, input logic err,
                          input logic [31:0] rdata, input int rr_delay, input string name);
        logic        to;
        int          exp_vcyc;
        int          vcyc;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        logic [68:0] exp_req;
        logic [35:0] exp_rsp;
        logic [35:0] got_rsp;
        to       = (delay >= int'(TO));
        exp_vcyc = to ? int'(TO) : delay + 1;
        exp_resp = (to || err) ? SLVERR : OKAY;
        exp_data = (to || wr) ? 32'h0 : rdata;
        exp_req  = {addr, wr, (wr ? data : 32'h0), (wr ? strb : 4'h0)};
        tgt_delay = delay;
        tgt_err   = err;
        tgt_rdata = rdata;
        if (wr) begin
            aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1;
        end else begin
            ar_addr = addr; ar_valid = 1'b1;
        end
        #1;
        check_cnt++;
        if ({aw_ready, w_ready, ar_ready} !== (wr ? 3'b110 : 3'b001))
            $display("FAIL %s accept: got %b required %b", name,
                     {aw_ready, w_ready, ar_ready}, (wr ? 3'b110 : 3'b001));
        else pass_cnt++;
        cyc();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        aw_addr = $urandom; ar_addr = $urandom; w_data = $urandom; w_strb = 4'($urandom);
        vcyc = 0;
        while (reg_req.valid && vcyc < 50) begin
            check_cnt++;
            if ({reg_req.addr, reg_req.write, reg_req.wdata, reg_req.wstrb} !== exp_req)
                $display("FAIL %s req_fields: got %h required %h", name,
                         {reg_req.addr, reg_req.write, reg_req.wdata, reg_req.wstrb}, exp_req);
            else pass_cnt++;
            vcyc++;
            cyc();
        end
        check_cnt++;
        if (vcyc !== exp_vcyc)
            $display("FAIL %s valid_cycles: got %0d required %0d", name, vcyc, exp_vcyc);
        else pass_cnt++;
        exp_rsp = wr ? {1'b1, 1'b0, exp_resp, 32'h0} : {1'b0, 1'b1, exp_resp, exp_data};
        for (int i = 0; i <= rr_delay; i++) begin
            got_rsp = wr ? {b_valid, r_valid, b_resp, 32'h0} : {b_valid, r_valid, r_resp, r_data};
            check_cnt++;
            if (got_rsp !== exp_rsp)
                $display("FAIL %s response[%0d]: got %h required %h", name, i, got_rsp, exp_rsp);
            else pass_cnt++;
            if (i == rr_delay) begin
                b_ready = wr;
                r_ready = !wr;
            end
            cyc();
        end
        b_ready = 1'b0; r_ready = 1'b0;
        check_cnt++;
        if ({b_valid, r_valid} !== 2'b00)
            $display("FAIL %s resp_drop: got %b required 00", name, {b_valid, r_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) cyc();
        check_cnt++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, reg_req} !== '0)
            $display("FAIL reset_state: got %h required 0",
                     {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, reg_req});
        else pass_cnt++;
        rst_ni = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        do_txn(1'b1, 32'h0C00_0004, 32'h5, 4'hF, 0, 1'b0, 32'h0, 0, "write");
    endtask

    task automatic test_read();
        do_txn(1'b0, 32'h0C00_1000, 32'h0, 4'h0, 3, 1'b0, 32'h6, 0, "read");
    endtask

    task automatic test_error();
        do_txn(1'b1, 32'h0C00_000C, 32'hA5A5_0001, 4'h3, 1, 1'b1, 32'h0, 1, "write_err");
        do_txn(1'b0, 32'h0C00_0010, 32'h0, 4'h0, 0, 1'b1, 32'h1234_5678, 0, "read_err");
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 32'h0C00_2000, 32'h0, 4'h0, 1000, 1'b0, 32'hDEAD_BEEF, 0, "rd_timeout");
        do_txn(1'b1, 32'h0C00_2004, 32'h77, 4'h1, 1000, 1'b0, 32'h0, 2, "wr_timeout");
        do_txn(1'b0, 32'h0C00_2008, 32'h0, 4'h0, 2, 1'b0, 32'hCAFE_F00D, 5, "rd_hold");
    endtask

    task automatic test_contention();
        logic [2:0] exp_seq [3];
        int n;
        int guard;
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b110; exp_seq[2] = 3'b001;
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        cyc();
        tgt_delay = 0; tgt_err = 1'b0; tgt_rdata = 32'h1;
        aw_addr = 32'h0C00_0100; w_data = 32'h9; w_strb = 4'hF; ar_addr = 32'h0C00_0200;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
        #1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 40) begin
            if (aw_ready || w_ready || ar_ready) begin
                check_cnt++;
                if ({aw_ready, w_ready, ar_ready} !== exp_seq[n])
                    $display("FAIL contention_order[%0d]: got %b required %b", n,
                             {aw_ready, w_ready, ar_ready}, exp_seq[n]);
                else pass_cnt++;
                check_cnt++;
                if ({reg_req.valid, b_valid, r_valid} !== 3'b000)
                    $display("FAIL contention_outstanding[%0d]: got %b required 000", n,
                             {reg_req.valid, b_valid, r_valid});
                else pass_cnt++;
                n++;
            end
            cyc();
            guard++;
        end
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        check_cnt++;
        if (n !== 3) $display("FAIL contention_accepts: got %0d required 3", n);
        else pass_cnt++;
        guard = 0;
        while ((reg_req.valid || b_valid || r_valid) && guard < 20) begin
            cyc();
            guard++;
        end
        b_ready = 1'b0; r_ready = 1'b0;
        check_cnt++;
        if ({reg_req.valid, b_valid, r_valid} !== 3'b000)
            $display("FAIL contention_drain: got %b required 000", {reg_req.valid, b_valid, r_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen;
        tgt_delay = 1000; tgt_err = 1'b0; tgt_rdata = 32'h55;
        ar_addr = 32'h0C00_3000; ar_valid = 1'b1;
        cyc();
        cyc();
        check_cnt++;
        if (reg_req.valid !== 1'b1) $display("FAIL mid_reset_inreq: got %b required 1", reg_req.valid);
        else pass_cnt++;
        #2;
        rst_ni = 1'b0;
        #1;
        check_cnt++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, reg_req} !== '0)
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, reg_req});
        else pass_cnt++;
        ar_valid = 1'b0;
        cyc();
        rst_ni = 1'b1;
        seen = 0;
        r_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (r_valid || reg_req.valid) seen++;
            cyc();
        end
        r_ready = 1'b0;
        check_cnt++;
        if (seen !== 0) $display("FAIL mid_reset_no_beat: got %0d cycles active required 0", seen);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic wr;
        int   delay;
        for (int i = 0; i < 16; i++) begin
            wr    = 1'($urandom_range(0, 1));
            delay = ($urandom_range(0, 4) == 0) ? 1000 : int'($urandom_range(0, 4));
            do_txn(wr, $urandom, $urandom, 4'($urandom_range(0, 15)), delay,
                   ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_reset_mid();
        test_contention();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

`default_nettype wire
